// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and types for the scoreboarded register file.
package reg_file_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_CNT_W = 2;
  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;
  typedef logic [DEF_CNT_W-1:0] pend_cnt_t;
  localparam pend_cnt_t PEND_MAX = '1;
endpackage

// File: rtl/reg_file_sb_counter.sv
// sb_counter: saturating pending-write counter; +inc -dec_a -dec_b per edge, err on clamp.
module sb_counter
  import reg_file_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  localparam int MAX = (1 << CNT_W) - 1;
  logic signed [31:0] nxt;
  logic [CNT_W-1:0] cnt_n;
  always_comb begin
    nxt = int'(cnt) + int'(inc) - int'(dec_a) - int'(dec_b);
    err = nxt > MAX || nxt < 0;
    cnt_n = nxt > MAX ? cnt : nxt < 0 ? '0 : CNT_W'(nxt);
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) cnt <= '0;
    else cnt <= cnt_n;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-register pending-write scoreboard.
// Define RF_WRITE_BYPASS_EN to forward same-cycle writeback data and retire to the read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD = 2,
  parameter int CNT_W = DEF_CNT_W,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_RD*AW-1:0]   ra_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      busy_o,
  input  logic                   we_i,
  input  logic [AW-1:0]          wa_i,
  input  logic [XLEN-1:0]        wd_i,
  input  logic                   issue_i,
  input  logic [AW-1:0]          issue_rd_i,
  input  logic                   cancel_i,
  input  logic [AW-1:0]          cancel_rd_i,
  output logic                   overflow_o
);
  logic [XLEN-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] err;
  logic ovf;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    if (i == 0) begin : g_zero
      assign cnt[i] = '0;
      assign err[i] = 1'b0;
    end else begin : g_reg
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc     (issue_i && issue_rd_i == AW'(i)),
        .dec_a   (we_i && wa_i == AW'(i)),
        .dec_b   (cancel_i && cancel_rd_i == AW'(i)),
        .cnt     (cnt[i]),
        .err     (err[i])
      );
    end
  end
  // regs[0] is never written, so it stays at its reset value of zero
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (we_i && wa_i != '0) regs[wa_i] <= wd_i;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) ovf <= 1'b0;
    else if (|err) ovf <= 1'b1;
  assign overflow_o = ovf;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = ra_i[k*AW +: AW];
`ifdef RF_WRITE_BYPASS_EN
    logic hit;
    assign hit = reset_i && we_i && wa_i != '0 && wa_i == a;
    assign rd_data_o[k*XLEN +: XLEN] = hit ? wd_i : regs[a];
    assign busy_o[k] = hit ? cnt[a] > CNT_W'(1) : cnt[a] != '0;
`else
    assign rd_data_o[k*XLEN +: XLEN] = regs[a];
    assign busy_o[k] = cnt[a] != '0;
`endif
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scenarios plus randomized traffic against a reference model.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [9:0]  ra_i = '0;
  logic [63:0] rd_data_o;
  logic [1:0]  busy_o;
  logic        we_i = 1'b0;
  logic [4:0]  wa_i = '0;
  logic [31:0] wd_i = '0;
  logic        issue_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic        cancel_i = 1'b0;
  logic [4:0]  cancel_rd_i = '0;
  logic        overflow_o;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] reg_m [32];
  int cnt_m [32];
  bit ovf_m;

  reg_file_sb dut (
    .clk_i(clk), .reset_i(reset_i), .ra_i(ra_i), .rd_data_o(rd_data_o), .busy_o(busy_o),
    .we_i(we_i), .wa_i(wa_i), .wd_i(wd_i), .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .cancel_i(cancel_i), .cancel_rd_i(cancel_rd_i), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  function automatic void clear_model();
    for (int r = 0; r < 32; r++) begin
      reg_m[r] = '0;
      cnt_m[r] = 0;
    end
    ovf_m = 1'b0;
  endfunction

  // Each register moves by issues minus retires minus cancels, clamped to 0..3
  function automatic void upd_model();
    int n;
    for (int r = 1; r < 32; r++) begin
      n = cnt_m[r] + ((issue_i && issue_rd_i == r) ? 1 : 0)
                   - ((we_i && wa_i == r) ? 1 : 0)
                   - ((cancel_i && cancel_rd_i == r) ? 1 : 0);
      if (n > 3) ovf_m = 1'b1;
      else if (n < 0) begin
        ovf_m = 1'b1;
        cnt_m[r] = 0;
      end else cnt_m[r] = n;
    end
    if (we_i && wa_i != 0) reg_m[wa_i] = wd_i;
  endfunction

  function automatic bit bypass_hit(int k);
    logic [4:0] a;
    a = ra_i[k*5 +: 5];
`ifdef RF_WRITE_BYPASS_EN
    return reset_i && we_i && wa_i != 0 && wa_i == a;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_rd(int k);
    logic [4:0] a;
    a = ra_i[k*5 +: 5];
    return bypass_hit(k) ? wd_i : reg_m[a];
  endfunction

  function automatic logic exp_busy(int k);
    logic [4:0] a;
    a = ra_i[k*5 +: 5];
    return bypass_hit(k) ? (cnt_m[a] > 1) : (cnt_m[a] != 0);
  endfunction

  task automatic idle();
    we_i = 1'b0;
    issue_i = 1'b0;
    cancel_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_i) upd_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1'b0;
    clear_model();
    @(negedge clk);
    reset_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    clear_model();
    @(negedge clk);
    ra_i = {5'd0, 5'd5};
    we_i = 1'b1; wa_i = 5'd5; wd_i = 32'hDEADBEEF;
    #1;
    n_chk++; if (rd_data_o[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_rd_held: got %h want 0", rd_data_o[31:0]); end
    n_chk++; if (busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy_held: got %b want 0", busy_o[0]); end
    tick();
    n_chk++; if (rd_data_o[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_write_ignored: got %h want 0", rd_data_o[31:0]); end
    n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
    reset_i = 1'b1;
    tick();
    idle();
    #1;
    n_chk++; if (rd_data_o[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset_first_write: got %h want deadbeef", rd_data_o[31:0]); end
    n_chk++; if (busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_first_busy: got %b want 0", busy_o[0]); end
  endtask

  task automatic test_reset_midcycle();
    do_reset();
    ra_i = {5'd6, 5'd6};
    issue_i = 1'b1; issue_rd_i = 5'd6;
    we_i = 1'b1; wa_i = 5'd6; wd_i = 32'h0000_0055;
    #2 reset_i = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    n_chk++; if (rd_data_o[31:0] !== 32'h0) begin n_fail++; $display("FAIL midreset_rd: got %h want 0", rd_data_o[31:0]); end
    n_chk++; if (busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy_o[0]); end
    @(negedge clk);
    idle();
    reset_i = 1'b1;
    tick();
    #1;
    n_chk++; if (busy_o[1] !== 1'b0 || rd_data_o[63:32] !== 32'h0) begin n_fail++; $display("FAIL midreset_after: got busy %b rd %h want 0 0", busy_o[1], rd_data_o[63:32]); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    ra_i = {5'd0, 5'd0};
    issue_i = 1'b1; issue_rd_i = 5'd0;
    we_i = 1'b1; wa_i = 5'd0; wd_i = 32'h1234;
    cancel_i = 1'b1; cancel_rd_i = 5'd0;
    tick();
    idle();
    #1;
    n_chk++; if (rd_data_o !== 64'h0) begin n_fail++; $display("FAIL x0_rd: got %h want 0", rd_data_o); end
    n_chk++; if (busy_o !== 2'b00) begin n_fail++; $display("FAIL x0_busy: got %b want 00", busy_o); end
    n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL x0_ovf: got %b want 0", overflow_o); end
  endtask

  task automatic test_pending();
    logic [31:0] d;
    do_reset();
    ra_i = {5'd0, 5'd7};
    for (int i = 0; i < 3; i++) begin
      issue_i = 1'b1; issue_rd_i = 5'd7;
      tick();
      idle();
      #1;
      n_chk++; if (busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL pend_issue%0d: got busy %b want 1", i, busy_o[0]); end
    end
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      we_i = 1'b1; wa_i = 5'd7; wd_i = d;
      tick();
      idle();
      #1;
      n_chk++; if (busy_o[0] !== (i < 2)) begin n_fail++; $display("FAIL pend_retire%0d: got busy %b want %b", i, busy_o[0], i < 2); end
      n_chk++; if (rd_data_o[31:0] !== d) begin n_fail++; $display("FAIL pend_data%0d: got %h want %h", i, rd_data_o[31:0], d); end
    end
    n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL pend_no_ovf: got %b want 0", overflow_o); end
    for (int i = 0; i < 4; i++) begin
      issue_i = 1'b1; issue_rd_i = 5'd7;
      tick();
    end
    idle();
    #1;
    n_chk++; if (overflow_o !== 1'b1 || busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL pend_saturate: got ovf %b busy %b want 1 1", overflow_o, busy_o[0]); end
    for (int i = 0; i < 3; i++) begin
      we_i = 1'b1; wa_i = 5'd7; wd_i = $urandom;
      tick();
      idle();
      #1;
      n_chk++; if (busy_o[0] !== (i < 2)) begin n_fail++; $display("FAIL pend_drain%0d: got busy %b want %b", i, busy_o[0], i < 2); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ra_i = {5'd3, 5'd0};
    issue_i = 1'b1; issue_rd_i = 5'd3;
    tick();
    we_i = 1'b1; wa_i = 5'd3; wd_i = $urandom;
    tick();
    idle();
    #1;
    n_chk++; if (busy_o[1] !== 1'b1) begin n_fail++; $display("FAIL simul_issue_retire: got busy %b want 1", busy_o[1]); end
    issue_i = 1'b1; issue_rd_i = 5'd3;
    tick();
    idle();
    we_i = 1'b1; wa_i = 5'd3; wd_i = $urandom;
    cancel_i = 1'b1; cancel_rd_i = 5'd3;
    tick();
    idle();
    #1;
    n_chk++; if (busy_o[1] !== 1'b0) begin n_fail++; $display("FAIL simul_minus2: got busy %b want 0", busy_o[1]); end
    n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL simul_ovf: got %b want 0", overflow_o); end
  endtask

  task automatic test_bypass();
    do_reset();
    issue_i = 1'b1; issue_rd_i = 5'd9;
    tick();
    idle();
    ra_i = {5'd0, 5'd9};
    we_i = 1'b1; wa_i = 5'd9; wd_i = 32'hA5A5A5A5;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    n_chk++; if (rd_data_o[31:0] !== 32'hA5A5A5A5 || busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL bypass_same_cycle: got %h busy %b want a5a5a5a5 0", rd_data_o[31:0], busy_o[0]); end
`else
    n_chk++; if (rd_data_o[31:0] !== 32'h0 || busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL nobypass_same_cycle: got %h busy %b want 0 1", rd_data_o[31:0], busy_o[0]); end
`endif
    tick();
    idle();
    #1;
    n_chk++; if (rd_data_o[31:0] !== 32'hA5A5A5A5 || busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL bypass_after: got %h busy %b want a5a5a5a5 0", rd_data_o[31:0], busy_o[0]); end
  endtask

  task automatic test_underflow();
    do_reset();
    ra_i = {5'd0, 5'd4};
    cancel_i = 1'b1; cancel_rd_i = 5'd4;
    tick();
    idle();
    #1;
    n_chk++; if (overflow_o !== 1'b1 || busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL underflow: got ovf %b busy %b want 1 0", overflow_o, busy_o[0]); end
    repeat (5) tick();
    n_chk++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b want 1", overflow_o); end
    do_reset();
    #1;
    n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL underflow_cleared: got %b want 0", overflow_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      issue_i = 1'($urandom_range(0, 1)); issue_rd_i = 5'($urandom_range(0, 7));
      we_i = 1'($urandom_range(0, 1)); wa_i = 5'($urandom_range(0, 7)); wd_i = $urandom;
      cancel_i = ($urandom_range(0, 3) == 0); cancel_rd_i = 5'($urandom_range(0, 7));
      ra_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (rd_data_o[k*32 +: 32] !== exp_rd(k)) begin n_fail++; $display("FAIL rand_rd%0d cyc %0d: got %h want %h", k, c, rd_data_o[k*32 +: 32], exp_rd(k)); end
        n_chk++; if (busy_o[k] !== exp_busy(k)) begin n_fail++; $display("FAIL rand_busy%0d cyc %0d: got %b want %b", k, c, busy_o[k], exp_busy(k)); end
      end
      n_chk++; if (overflow_o !== ovf_m) begin n_fail++; $display("FAIL rand_ovf cyc %0d: got %b want %b", c, overflow_o, ovf_m); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_reset_midcycle();
    test_reg_zero();
    test_pending();
    test_simultaneous();
    test_bypass();
    test_underflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NUM_REGS, default 32, architectural register count; power of two, at least 2; AW = log2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, read/busy port count, 1..4.
REQ-004 SHALL have parameter CNT_W, default 2, pending-counter width per register.
REQ-005 SHALL have ports: clk_i in 1, the single clock; reset_i in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: ra_i in NUM_RD*AW, read addresses; rd_data_o out NUM_RD*XLEN, read data; busy_o out NUM_RD, pending write exists for ra.
REQ-007 SHALL have ports: we_i in 1, wa_i in AW, wd_i in XLEN; this is the writeback write port, and it also retires one pending write.
REQ-008 SHALL have ports: issue_i in 1, issue_rd_i in AW; these mark a new in-flight writer.
REQ-009 SHALL have ports: cancel_i in 1, cancel_rd_i in AW; these remove a flushed in-flight writer.
REQ-010 SHALL have port overflow_o out 1, a sticky flag set on counter saturation or underflow.

Function
REQ-011 SHALL store NUM_REGS-1 registers of XLEN bits; register 0 reads 0, ignores writes, and is never pending.
REQ-012 SHALL perform reads combinationally from ra_i; a write lands on the rising clk_i edge when we_i=1 and wa_i!=0.
REQ-013 SHALL keep one CNT_W-bit pending counter per register 1..NUM_REGS-1; busy_o[k] = (counter[ra_i[k]] != 0).
REQ-014 SHALL apply counter updates per edge as net delta = +issue -retire -cancel, with each term evaluated against its own address.
REQ-015 SHALL leave the counter unchanged when issue coincides with a retire or cancel on the same register.
REQ-016 SHALL apply a net -2 on one register (retire and cancel on the same address) in a single edge.
REQ-017 SHALL hold a counter at its maximum value when an issue would overflow it, and set overflow_o.
REQ-018 SHALL hold a counter at 0 when a retire or cancel would underflow it, and set overflow_o; the write data is still stored.
REQ-019 SHALL have busy_o reflect only registered counter state, so an issue at edge N raises busy after edge N, not combinationally.
REQ-020 SHALL ignore any issue, retire or cancel to register 0.
REQ-021 SHALL keep overflow_o high until reset.

Reset
REQ-022 SHALL, while reset_i=0, clear all registers, all counters and overflow_o to 0 asynchronously; rd_data_o=0 and busy_o=0.
REQ-023 SHALL drop any in-flight issue, write or cancel when reset asserts mid-cycle; there is no partial update.
REQ-024 SHALL act on the first clk_i edge after reset_i deasserts normally.

Configuration
REQ-025 SHALL support macro RF_WRITE_BYPASS_EN.
REQ-026 When RF_WRITE_BYPASS_EN is defined: if we_i=1, wa_i!=0 and wa_i==ra_i[k], rd_data_o[k]=wd_i in the same cycle, and busy_o[k] reads as if the retire had already applied (counter-1 != 0).
REQ-027 When RF_WRITE_BYPASS_EN is undefined: rd_data_o[k] shows stored data only, and busy_o[k] uses the current counter only.

Structure
REQ-028 SHALL place shared items in package reg_file_pkg: XLEN default, NUM_REGS default, typedef reg_addr_t, typedef pend_cnt_t, and constant PEND_MAX.
REQ-029 SHALL implement each per-register counter in one sub-module sb_counter (inputs inc, dec_a, dec_b; outputs cnt, err), instantiated NUM_REGS-1 times.
REQ-030 SHALL keep the read-mux and bypass logic in the top module.

Verification
REQ-031 Reset test: hold reset_i=0, write x5=0xDEADBEEF -> rd_data x5=0, busy=0; release reset, then write -> x5 reads 0xDEADBEEF the next cycle.
REQ-032 Register-zero test: issue x0, write x0=0x1234 -> rd_data x0=0, busy=0, overflow_o=0.
REQ-033 Pending-count test: issue x7 on three consecutive cycles, then retire x7 twice -> busy stays 1; third retire -> busy=0; a fourth issue with CNT_W=2 saturates at 3 and sets overflow_o=1.
REQ-034 Simultaneous-event test: with x3 count=1, issue x3 and retire x3 in the same cycle -> count stays 1, busy=1; retire and cancel x3 together from count 2 -> count 0.
REQ-035 Bypass test (RF_WRITE_BYPASS_EN defined): with x9 count=1, drive ra=9 and write x9=0xA5A5A5A5 -> rd_data=0xA5A5A5A5 and busy=0 in the same cycle; with the macro undefined, the old value is read and busy=1.
REQ-036 Underflow test: cancel x4 at count 0 -> count stays 0 and overflow_o=1, and it remains 1 until reset.
